rv_ctrl_alu: RTL and testbench
==============================

Name: rv_ctrl_alu

Overview:
- Combined decode/execute slice of the RV32I pipeline: main control decoder, ALU-operation decoder and 32-bit ALU in one block.
- Takes the ID-stage instruction and operands and produces control flags, ALU result and zero flag.
- All outputs are registered once, so the block also serves as the ID/EX-to-EX/MEM boundary.
- Feeds the data-memory and write-back stages.

Parameters:
- DATA_W, 32, operand/result width (only 32 supported).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous and active-high; clears all outputs.
- valid_i  in  1  instruction slot valid; 0 inserts a bubble.
- inst_i  in  32  instruction word.
- rs1_data_i  in  32  source-1 operand (already forwarded).
- rs2_data_i  in  32  source-2 operand (already forwarded).
- imm_i  in  32  sign-extended immediate.
- branch_o  out  1  registered Branch.
- mem_read_o  out  1  registered MemRead.
- mem_to_reg_o  out  1  registered MemtoReg.
- mem_write_o  out  1  registered MemWrite.
- reg_write_o  out  1  registered RegWrite.
- alu_result_o  out  32  registered ALU result.
- zero_o  out  1  registered (result == 0).
- store_data_o  out  32  registered rs2_data_i.

Behaviour:
- Reset: all outputs 0, asynchronously; the first capture happens on the first rising edge after rst_i falls.
- Latency: exactly 1 cycle. Outputs reflect the inputs present at the previous rising edge. No stall or handshake; a new instruction is accepted every cycle.
- Opcode decode, giving {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}:
  - R-type 0110011: 000001, B = rs2.
  - I-ALU 0010011: 000011, B = imm.
  - Load 0000011: 011011.
  - Store 0100011: 000110.
  - Branch 1100011 (BEQ only): 100000, B = rs2.
  - Any other opcode, or valid_i=0: all flags 0, ALUOp = ADD. Result is still computed but is harmless.
- ALUOp (4 bits) from the control decoder:
  - R-type: {funct7[5], funct3}.
  - I-ALU: {funct3==101 ? funct7[5] : 0, funct3}. SUB is not reachable from I-type.
  - Load/store: 0000 (ADD).
  - Branch: 1000 (SUB).
- ALU control map (4-bit ALUOp to 6-bit ALU op code):
  - 0000 ADD = 0, 1000 SUB = 1, x001 SLL = 2, x010 SLT = 3, x011 SLTU = 4.
  - x100 XOR = 5, 0101 SRL = 6, 1101 SRA = 7, x110 OR = 8, x111 AND = 9.
  - Unmapped ALU op codes 10..63 produce result 0.
- ALU arithmetic:
  - ADD and SUB wrap modulo 2^32; no overflow flag.
  - Shift amount is B[4:0]. SRA sign-fills.
  - SLT compares signed and SLTU unsigned; both produce 32'd0 or 32'd1.
  - zero = (result == 0). It is computed for every op, not only branches.
- Branch taken is decided downstream as branch_o & zero_o; this block does not redirect the PC.
- Reset mid-stream: outputs clear immediately, and the in-flight instruction is lost.

Optional Feature:
- Macro: RV_CTRL_ALU_ILLEGAL_EN.
- Defined:
  - Adds output port illegal_o (1 bit, registered, reset 0).
  - Asserted for valid_i=1 with an unknown opcode, R-type funct7 not in {0000000, 0100000}, funct7=0100000 with funct3 not in {000, 101}, or branch funct3 != 000.
  - On assertion all control flags are forced to 0.
- Undefined: no illegal_o port; those encodings decode per the tables above (unknown opcode gives a bubble).

Decomposition:
- Package rv_ctrl_alu_pkg holds:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH);
  - the 4-bit ALUOp encodings;
  - the 6-bit ALU op-code constants;
  - a packed control-flag struct typedef.
- One natural sub-module: rv_alu_core, a purely combinational ALU taking A, B and the 6-bit op code and returning result and zero.
- Control and ALU-control decode stay in the top as combinational always blocks.

Test Plan:
- Reset: assert rst_i mid-cycle with outputs nonzero -> all outputs 0 immediately, no clock needed.
- R-type add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle alu_result_o=12, reg_write_o=1, zero_o=0, other flags 0.
- sub (0x402081B3), rs1=rs2=0x1234 -> result 0, zero_o=1. With rs1=0, rs2=1 the result is 0xFFFFFFFF.
- srai (funct3=101, funct7=0100000), rs1=0x80000000, imm=4 -> result 0xF8000000. The same encoding as srli gives 0x08000000.
- lw (opcode 0000011), rs1=0x100, imm=0xFFFFFFFC -> result 0xFC, mem_read_o=1, mem_to_reg_o=1, reg_write_o=1. sw -> result = address, mem_write_o=1, store_data_o = rs2.
- beq with rs1=rs2=9 -> branch_o=1, zero_o=1. With rs1=9, rs2=8 -> zero_o=0. With valid_i=0 on any instruction -> all flags 0. Back-to-back instructions every cycle each appear exactly 1 cycle later.

Source files
------------

// File: rtl/rv_ctrl_alu_pkg.sv
// Shared definitions for the RV32I decode/execute slice: opcode constants,
// ALUOp encodings, ALU op codes and the control-flag structs.
package rv_ctrl_alu_pkg;

  // Major opcodes (inst[6:0]) handled by this slice
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // 4-bit ALUOp from the main decoder: {funct7[5] or SUB select, funct3}
  localparam logic [3:0] ALUOP_ADD = 4'b0000;
  localparam logic [3:0] ALUOP_SUB = 4'b1000;

  // 6-bit ALU op codes consumed by rv_alu_core; 10..63 yield a zero result
  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_SUB  = 6'd1;
  localparam logic [5:0] ALU_SLL  = 6'd2;
  localparam logic [5:0] ALU_SLT  = 6'd3;
  localparam logic [5:0] ALU_SLTU = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SRL  = 6'd6;
  localparam logic [5:0] ALU_SRA  = 6'd7;
  localparam logic [5:0] ALU_OR   = 6'd8;
  localparam logic [5:0] ALU_AND  = 6'd9;

  // Full decoder output, MSB-first in the classic table order
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
  } ctrl_t;

  // The subset of control that travels on to MEM/WB
  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic reg_write;
  } out_flags_t;

  // Map a 4-bit ALUOp onto the ALU op code
  function automatic logic [5:0] alu_ctrl(input logic [3:0] alu_op);
    logic [5:0] code;
    unique case (alu_op[2:0])
      3'b000:  code = alu_op[3] ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alu_op[3] ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/rv_alu_core.sv
// Purely combinational 32-bit RV32I ALU: result and zero flag from A, B and
// a 6-bit op code. Unmapped op codes give a zero result.
module rv_alu_core
  import rv_ctrl_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [5:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  // Select the operation; every path assigns result_o
  always_comb begin
    // NOTE: default assigned first so no path through the case leaves
    // result_o unassigned, which would otherwise infer a latch.
    result_o = '0;
    unique case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/rv_ctrl_alu.sv
// RV32I decode/execute slice: main control decoder, ALU-operation decoder
// and ALU, with every output registered once (ID/EX to EX/MEM boundary).
// Optional: define RV_CTRL_ALU_ILLEGAL_EN to add the illegal_o port, which
// flags unsupported encodings and squashes their control flags.
module rv_ctrl_alu
  import rv_ctrl_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [31:0]       inst_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  output logic              branch_o,
  output logic              mem_read_o,
  output logic              mem_to_reg_o,
  output logic              mem_write_o,
  output logic              reg_write_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic              zero_o,
  output logic [DATA_W-1:0] store_data_o
`ifdef RV_CTRL_ALU_ILLEGAL_EN
  ,
  output logic              illegal_o
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  // Register/immediate fields are decoded upstream; only the xor keeps them visible
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

  ctrl_t       ctrl;
  logic [3:0]  alu_op;
  logic        illegal;

  // Main control decode: flags and ALUOp from the opcode
  always_comb begin
    ctrl    = '0;
    alu_op  = ALUOP_ADD;
    illegal = 1'b0;
    if (valid_i) begin
      unique case (opcode)
        OP_R: begin
          ctrl   = 6'b000001;
          alu_op = {funct7[5], funct3};
`ifdef RV_CTRL_ALU_ILLEGAL_EN
          if (funct7 != 7'b0000000 && funct7 != 7'b0100000) illegal = 1'b1;
          if (funct7 == 7'b0100000 && funct3 != 3'b000 && funct3 != 3'b101) illegal = 1'b1;
`endif
        end
        OP_IMM: begin
          ctrl   = 6'b000011;
          alu_op = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
        end
        OP_LOAD:  ctrl = 6'b011011;
        OP_STORE: ctrl = 6'b000110;
        OP_BRANCH: begin
          ctrl   = 6'b100000;
          alu_op = ALUOP_SUB;
`ifdef RV_CTRL_ALU_ILLEGAL_EN
          if (funct3 != 3'b000) illegal = 1'b1;
`endif
        end
        default: begin
`ifdef RV_CTRL_ALU_ILLEGAL_EN
          illegal = 1'b1;
`endif
        end
      endcase
    end
`ifdef RV_CTRL_ALU_ILLEGAL_EN
    if (illegal) ctrl = '0;
`endif
  end

  // ALU operand select and execute
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;

  assign alu_b = ctrl.alu_src ? imm_i : rs2_data_i;

  rv_alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (rs1_data_i),
    .b_i      (alu_b),
    .op_i     (alu_ctrl(alu_op)),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Pipeline-register next state
  out_flags_t        flags_d,      flags_q;
  logic [DATA_W-1:0] result_d,     result_q;
  logic              zero_d,       zero_q;
  logic [DATA_W-1:0] store_data_d, store_data_q;
  logic              illegal_d,    illegal_q;

  // Assemble the values captured at the next edge
  always_comb begin
    flags_d      = '{branch:     ctrl.branch,
                     mem_read:   ctrl.mem_read,
                     mem_to_reg: ctrl.mem_to_reg,
                     mem_write:  ctrl.mem_write,
                     reg_write:  ctrl.reg_write};
    result_d     = alu_result;
    zero_d       = alu_zero;
    store_data_d = rs2_data_i;
    illegal_d    = illegal;
  end

  // Output register; asynchronous reset clears everything
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values
    // regardless of statement order.
    if (rst_i) begin
      flags_q      <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      store_data_q <= '0;
      illegal_q    <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      store_data_q <= store_data_d;
      illegal_q    <= illegal_d;
    end
  end

  assign branch_o     = flags_q.branch;
  assign mem_read_o   = flags_q.mem_read;
  assign mem_to_reg_o = flags_q.mem_to_reg;
  assign mem_write_o  = flags_q.mem_write;
  assign reg_write_o  = flags_q.reg_write;
  assign alu_result_o = result_q;
  assign zero_o       = zero_q;
  assign store_data_o = store_data_q;

`ifdef RV_CTRL_ALU_ILLEGAL_EN
  assign illegal_o = illegal_q;
`else
  logic unused_illegal_q;
  assign unused_illegal_q = illegal_q;
`endif

endmodule

// File: tb/tb_rv_ctrl_alu.sv
// Self-checking bench for rv_ctrl_alu: table of vectors driven back-to-back,
// expectations queued at drive time and popped one cycle later.
module tb_rv_ctrl_alu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [31:0] inst_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic        branch_o, mem_read_o, mem_to_reg_o, mem_write_o, reg_write_o;
  logic [31:0] alu_result_o;
  logic        zero_o;
  logic [31:0] store_data_o;
`ifdef RV_CTRL_ALU_ILLEGAL_EN
  logic        illegal_o;
`endif

  rv_ctrl_alu #(.DATA_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .inst_i       (inst_i),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .imm_i        (imm_i),
    .branch_o     (branch_o),
    .mem_read_o   (mem_read_o),
    .mem_to_reg_o (mem_to_reg_o),
    .mem_write_o  (mem_write_o),
    .reg_write_o  (reg_write_o),
    .alu_result_o (alu_result_o),
    .zero_o       (zero_o),
    .store_data_o (store_data_o)
`ifdef RV_CTRL_ALU_ILLEGAL_EN
    ,
    .illegal_o    (illegal_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Flags field order: {branch, mem_read, mem_to_reg, mem_write, reg_write}
  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  flags;
    logic [31:0] result;
    logic        zero;
    logic        ill;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  flags;
    logic [31:0] result;
    logic        zero;
    logic [31:0] store;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic add_vec(input string name, input logic valid, input logic [31:0] inst,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic [4:0] flags, input logic [31:0] result, input logic ill);
    vec_t v;
    v.name = name; v.valid = valid; v.inst = inst; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.flags = flags; v.result = result; v.zero = (result == 32'd0); v.ill = ill;
    vecs.push_back(v);
  endtask

  // Drive one vector and queue its expectation
  task automatic drive(input vec_t v);
    exp_t e;
    valid_i = v.valid; inst_i = v.inst; rs1_data_i = v.rs1; rs2_data_i = v.rs2; imm_i = v.imm;
    e.name = v.name; e.flags = v.flags; e.result = v.result; e.zero = v.zero;
    e.store = v.rs2; e.ill = v.ill;
    sb.push_back(e);
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.name, ".flags"}, {27'd0, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, reg_write_o},
          {27'd0, e.flags});
    check({e.name, ".result"}, alu_result_o, e.result);
    check({e.name, ".zero"}, {31'd0, zero_o}, {31'd0, e.zero});
    check({e.name, ".store"}, store_data_o, e.store);
`ifdef RV_CTRL_ALU_ILLEGAL_EN
    check({e.name, ".illegal"}, {31'd0, illegal_o}, {31'd0, e.ill});
`endif
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".flags"}, {27'd0, branch_o, mem_read_o, mem_to_reg_o, mem_write_o, reg_write_o}, 32'd0);
    check({name, ".result"}, alu_result_o, 32'd0);
    check({name, ".zero"}, {31'd0, zero_o}, 32'd0);
    check({name, ".store"}, store_data_o, 32'd0);
`ifdef RV_CTRL_ALU_ILLEGAL_EN
    check({name, ".illegal"}, {31'd0, illegal_o}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] rw_flags;
    // Table: name, valid, inst, rs1, rs2, imm, flags, result, illegal
    add_vec("add",      1, 32'h002081B3, 32'd5,        32'd7,        32'd0,        5'b00001, 32'd12,        0);
    add_vec("sub_eq",   1, 32'h402081B3, 32'h1234,     32'h1234,     32'd0,        5'b00001, 32'd0,         0);
    add_vec("sub_neg",  1, 32'h402081B3, 32'd0,        32'd1,        32'd0,        5'b00001, 32'hFFFFFFFF,  0);
    add_vec("add_wrap", 1, 32'h002081B3, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b00001, 32'd0,         0);
    add_vec("srai",     1, 32'h4040D193, 32'h80000000, 32'd0,        32'd4,        5'b00001, 32'hF8000000,  0);
    add_vec("srli",     1, 32'h0040D193, 32'h80000000, 32'd0,        32'd4,        5'b00001, 32'h08000000,  0);
    add_vec("addi_b30", 1, 32'h40008193, 32'h100,      32'd0,        32'h400,      5'b00001, 32'h500,       0);
    add_vec("addi_z",   1, 32'h00508193, 32'd1,        32'd9,        32'hFFFFFFFF, 5'b00001, 32'd0,         0);
    add_vec("lw",       1, 32'hFFC0A183, 32'h100,      32'h55,       32'hFFFFFFFC, 5'b01101, 32'hFC,        0);
    add_vec("sw",       1, 32'h0020A423, 32'h200,      32'hDEADBEEF, 32'd8,        5'b00010, 32'h208,       0);
    add_vec("beq_eq",   1, 32'h00208063, 32'd9,        32'd9,        32'd0,        5'b10000, 32'd0,         0);
    add_vec("beq_ne",   1, 32'h00208063, 32'd9,        32'd8,        32'd0,        5'b10000, 32'd1,         0);
    add_vec("slt",      1, 32'h0020A1B3, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b00001, 32'd1,         0);
    add_vec("sltu",     1, 32'h0020B1B3, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b00001, 32'd0,         0);
    add_vec("xor",      1, 32'h0020C1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'b00001, 32'h0FF00FF0,  0);
    add_vec("or",       1, 32'h0020E1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'b00001, 32'hFFF0FFF0,  0);
    add_vec("and",      1, 32'h0020F1B3, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        5'b00001, 32'hF000F000,  0);
    add_vec("sll",      1, 32'h002091B3, 32'd1,        32'h21,       32'd0,        5'b00001, 32'd2,         0);
    add_vec("sra_r",    1, 32'h4020D1B3, 32'h80000000, 32'd31,       32'd0,        5'b00001, 32'hFFFFFFFF,  0);
    add_vec("bubble",   0, 32'h402081B3, 32'd5,        32'd7,        32'd0,        5'b00000, 32'd12,        0);
    add_vec("bad_op",   1, 32'h0000007F, 32'd3,        32'd4,        32'd0,        5'b00000, 32'd7,         1);
`ifdef RV_CTRL_ALU_ILLEGAL_EN
    rw_flags = 5'b00000;
`else
    rw_flags = 5'b00001;
`endif
    add_vec("slt_f7",   1, 32'h4020A1B3, 32'hFFFFFFFF, 32'd1,        32'd0,        rw_flags, 32'd1,         1);

    // Reset state, asserted before any clock edge
    rst_i = 1'b1; valid_i = 1'b0; inst_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    #1;
    check_all_zero("reset_init");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Back-to-back table: drive every cycle, compare one cycle later
    @(posedge clk_i); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk_i); #1;
      compare_outputs();
    end

    // Mid-cycle reset with outputs nonzero: clears without a clock edge
    drive(vecs[0]);
    @(posedge clk_i); #1;
    compare_outputs();
    drive(vecs[9]);           // in-flight instruction that reset must discard
    sb.delete();
    #2;
    rst_i = 1'b1;
    #1;
    check_all_zero("reset_mid");
    @(posedge clk_i); #1;
    check_all_zero("reset_held");
    @(negedge clk_i);
    rst_i = 1'b0;

    // First capture after reset release is the instruction now present
    drive(vecs[10]);
    @(posedge clk_i); #1;
    compare_outputs();
    drive(vecs[4]);
    @(posedge clk_i); #1;
    compare_outputs();

    check("scoreboard_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
